// File: rtl/uart_rx_drain_ctrl_pkg.sv
// Shared encodings for the UART receive-FIFO drain controller.
// FIFO entry layout, trigger-level codes and FSM state codes.
package uart_rx_drain_ctrl_pkg;

  localparam logic [1:0] UART_FC_TRIG_1  = 2'b00;
  localparam logic [1:0] UART_FC_TRIG_4  = 2'b01;
  localparam logic [1:0] UART_FC_TRIG_8  = 2'b10;
  localparam logic [1:0] UART_FC_TRIG_14 = 2'b11;

  localparam int UART_REC_DATA_MSB = 10;
  localparam int UART_REC_DATA_LSB = 3;
  localparam int UART_REC_BRK      = 2;
  localparam int UART_REC_PE       = 1;
  localparam int UART_REC_FE       = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_POP  = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] err;
    logic       last;
  } hold_t;

  function automatic logic [4:0] trig_level(
    input logic [1:0] sel
  );
    logic [4:0] lvl;
    unique case (sel)
      UART_FC_TRIG_1:  lvl = 5'd1;
      UART_FC_TRIG_4:  lvl = 5'd4;
      UART_FC_TRIG_8:  lvl = 5'd8;
      UART_FC_TRIG_14: lvl = 5'd14;
      default:         lvl = 5'd1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_rx_drain_ctrl_if.sv
// Valid/ready byte stream from the drain controller to its sink.
// Carries the byte, its error flags and the end-of-burst marker.
interface uart_rx_drain_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] m_err;
  logic       m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_err,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_err,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART receive FIFO in bursts onto a valid/ready stream.
// Also produces level RDA/timeout indications and a sticky error flag.
module uart_rx_drain_ctrl
  import uart_rx_drain_ctrl_pkg::*;
#(
  parameter int FIFO_CNT_W  = 5,
  parameter int REC_W       = 11,
  parameter int MAX_BURST   = 16,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  drain_en,
  input  logic [1:0]            fcr_trig,
  input  logic [FIFO_CNT_W-1:0] rf_count,
  input  logic [REC_W-1:0]      rf_data_out,
  input  logic [9:0]            counter_t,
  output logic                  rf_pop,
  uart_rx_drain_if.master       m,
  output logic                  rda_int,
  output logic                  ti_int,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [4:0] burst_left_q;
  logic [4:0] burst_left_d;
  logic [4:0] burst_load;
  hold_t      hold_q;
  hold_t      hold_d;
  logic       rda_q;
  logic       rda_d;
  logic       ti_q;
  logic       ti_d;
  logic       err_q;
  logic       err_d;
  logic       err_set;
  logic       cnt_nz;
  logic       start;
  logic [7:0] head_data;
  logic [2:0] head_err;
  logic       head_last;

  always_comb begin
    head_data = rf_data_out[UART_REC_DATA_MSB:UART_REC_DATA_LSB];
    head_err  = {rf_data_out[UART_REC_BRK],
                 rf_data_out[UART_REC_PE],
                 rf_data_out[UART_REC_FE]};
    cnt_nz    = (rf_count != '0);
    // widen both sides so no trigger code is ever truncated
    rda_d     = 32'(rf_count) >= 32'(trig_level(fcr_trig));
    ti_d      = (counter_t == 10'd0) && cnt_nz;
    start     = rda_d || ti_d;
    if (32'(rf_count) > 32'(MAX_BURST)) begin
      burst_load = 5'(MAX_BURST);
    end else begin
      burst_load = 5'(rf_count);
    end
    head_last = (burst_left_q == 5'd1)
             || (32'(rf_count) == 32'd1)
             || ((STOP_ON_ERR != 0) && (|head_err));
  end

  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;
    hold_d       = hold_q;
    err_set      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (drain_en) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (start) begin
          burst_left_d = burst_load;
          state_d      = ST_POP;
        end else if (!drain_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        // an external pop may have emptied the FIFO; never pop empty
        if (cnt_nz) begin
          hold_d.data  = head_data;
          hold_d.err   = head_err;
          hold_d.last  = head_last;
          err_set      = |head_err;
          burst_left_d = burst_left_q - 5'd1;
          state_d      = ST_SEND;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_SEND: begin
        if (m.m_ready) begin
          if (hold_q.last) begin
            state_d = ST_ARM;
          end else if (!drain_en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_POP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      burst_left_q <= 5'd0;
      hold_q       <= '0;
      rda_q        <= 1'b0;
      ti_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      hold_q       <= hold_d;
      rda_q        <= rda_d;
      ti_q         <= ti_d;
      err_q        <= err_d;
    end
  end

  assign rf_pop     = (state_q == ST_POP) && cnt_nz;
  assign m.m_valid  = (state_q == ST_SEND);
  assign m.m_data   = hold_q.data;
  assign m.m_err    = hold_q.err;
  assign m.m_last   = hold_q.last;
  assign rda_int    = rda_q;
  assign ti_int     = ti_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed bench for uart_rx_drain_ctrl with a simple FIFO model.
// Each task drives one scenario and checks hand-computed values.
module tb_uart_rx_drain_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        drain_en = 1'b0;
  logic [1:0]  fcr_trig = 2'b00;
  logic [4:0]  rf_count;
  logic [10:0] rf_data_out;
  logic [9:0]  counter_t = 10'd100;
  logic        rf_pop;
  logic        rda_int;
  logic        ti_int;
  logic        err_sticky;
  logic        err_clr = 1'b0;

  uart_rx_drain_if sif();

  uart_rx_drain_ctrl dut (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .drain_en    (drain_en),
    .fcr_trig    (fcr_trig),
    .rf_count    (rf_count),
    .rf_data_out (rf_data_out),
    .counter_t   (counter_t),
    .rf_pop      (rf_pop),
    .m           (sif),
    .rda_int     (rda_int),
    .ti_int      (ti_int),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [10:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          pop_viol = 0;
  int          pop_times [$];
  logic        prev_pop = 1'b0;

  assign rf_count    = 5'(wr_ptr - rd_ptr);
  assign rf_data_out = mem[rd_ptr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_pop) rd_ptr <= rd_ptr + 8'd1;
  end

  always @(negedge clk) begin
    if (rf_pop === 1'b1) begin
      if (rf_count == 5'd0 || prev_pop) begin
        pop_viol = pop_viol + 1;
        $display("FAIL pop_rule count=%0d prev_pop=%0b required nonzero count, no back-to-back",
                 rf_count, prev_pop);
      end
      pop_times.push_back(cyc);
      pop_cnt = pop_cnt + 1;
    end
    prev_pop = (rf_pop === 1'b1);
  end

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    mem[wr_ptr] = {d, e};
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1'b1;
    drain_en = 1'b0;
    err_clr = 1'b0;
    sif.m_ready = 1'b0;
    counter_t = 10'd100;
    fcr_trig = 2'b00;
    wr_ptr = rd_ptr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  task automatic recv(output logic [7:0] d, output logic [2:0] e,
                      output logic l, output logic s, output bit ok);
    ok = 1'b0;
    d = '0;
    e = '0;
    l = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.m_valid && sif.m_ready) begin
        d = sif.m_data;
        e = sif.m_err;
        l = sif.m_last;
        s = err_sticky;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sif.m_valid !== 1'b0 || rf_pop !== 1'b0 || sif.m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl valid=%b pop=%b last=%b required 0 0 0",
               sif.m_valid, rf_pop, sif.m_last);
    end
    checks++;
    if (rda_int !== 1'b0 || ti_int !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags rda=%b ti=%b sticky=%b required 0 0 0",
               rda_int, ti_int, err_sticky);
    end
    checks++;
    if (sif.m_data !== 8'h00 || sif.m_err !== 3'b000) begin
      errors++;
      $display("FAIL reset_data data=%h err=%b required 00 000",
               sif.m_data, sif.m_err);
    end
  endtask

  task automatic test_trig4();
    logic [7:0] d; logic [2:0] e; logic l; logic s; bit ok;
    int base;
    do_reset();
    fcr_trig = 2'b01;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 3'b000);
    repeat (2) @(negedge clk);
    checks++;
    if (rda_int !== 1'b1 || ti_int !== 1'b0) begin
      errors++;
      $display("FAIL t1_rda rda=%b ti=%b required 1 0", rda_int, ti_int);
    end
    base = pop_cnt;
    sif.m_ready = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv(d, e, l, s, ok);
      checks++;
      if (!ok || d !== 8'(8'h41 + i) || l !== (i == 3)) begin
        errors++;
        $display("FAIL t1_byte%0d ok=%0b data=%h last=%b required data=%h last=%b",
                 i, ok, d, l, 8'(8'h41 + i), (i == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (pop_cnt - base !== 4) begin
      errors++;
      $display("FAIL t1_pops got=%0d required 4", pop_cnt - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_times[base+i+1] - pop_times[base+i] !== 2) begin
          errors++;
          $display("FAIL t1_spacing%0d got=%0d required 2", i,
                   pop_times[base+i+1] - pop_times[base+i]);
        end
      end
    end
    checks++;
    if (rda_int !== 1'b0) begin
      errors++;
      $display("FAIL t1_rda_end rda=%b required 0", rda_int);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic [2:0] e; logic l; logic s; bit ok;
    int base;
    do_reset();
    fcr_trig = 2'b11;
    for (int i = 0; i < 3; i++) push(8'(8'h51 + i), 3'b000);
    base = pop_cnt;
    sif.m_ready = 1'b1;
    drain_en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (pop_cnt - base !== 0 || ti_int !== 1'b0 || rda_int !== 1'b0) begin
      errors++;
      $display("FAIL t2_idle pops=%0d ti=%b rda=%b required 0 0 0",
               pop_cnt - base, ti_int, rda_int);
    end
    counter_t = 10'd0;
    @(negedge clk);
    checks++;
    if (ti_int !== 1'b1 || rda_int !== 1'b0) begin
      errors++;
      $display("FAIL t2_ti ti=%b rda=%b required 1 0", ti_int, rda_int);
    end
    for (int i = 0; i < 3; i++) begin
      recv(d, e, l, s, ok);
      checks++;
      if (!ok || d !== 8'(8'h51 + i) || l !== (i == 2)) begin
        errors++;
        $display("FAIL t2_byte%0d ok=%0b data=%h last=%b required data=%h last=%b",
                 i, ok, d, l, 8'(8'h51 + i), (i == 2));
      end
    end
    counter_t = 10'd100;
    drain_en = 1'b0;
  endtask

  task automatic test_max_burst();
    logic [7:0] d; logic [2:0] e; logic l; logic s; bit ok;
    int base;
    do_reset();
    fcr_trig = 2'b00;
    for (int i = 0; i < 20; i++) push(8'(8'h60 + i), 3'b000);
    base = pop_cnt;
    sif.m_ready = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      recv(d, e, l, s, ok);
      checks++;
      if (!ok || d !== 8'(8'h60 + i) || l !== (i == 15 || i == 19)) begin
        errors++;
        $display("FAIL t3_byte%0d ok=%0b data=%h last=%b required data=%h last=%b",
                 i, ok, d, l, 8'(8'h60 + i), (i == 15 || i == 19));
      end
    end
    @(negedge clk);
    checks++;
    if (pop_cnt - base !== 20) begin
      errors++;
      $display("FAIL t3_pops got=%0d required 20", pop_cnt - base);
    end else begin
      checks++;
      if (pop_times[base+16] - pop_times[base+15] !== 3) begin
        errors++;
        $display("FAIL t3_rearm gap=%0d required 3",
                 pop_times[base+16] - pop_times[base+15]);
      end
    end
    drain_en = 1'b0;
  endtask

  task automatic test_stop_on_err();
    logic [7:0] d; logic [2:0] e; logic l; logic s; bit ok;
    int base;
    do_reset();
    fcr_trig = 2'b01;
    push(8'h10, 3'b000);
    push(8'h11, 3'b001);
    push(8'h12, 3'b000);
    push(8'h13, 3'b000);
    base = pop_cnt;
    sif.m_ready = 1'b1;
    drain_en = 1'b1;
    recv(d, e, l, s, ok);
    checks++;
    if (!ok || d !== 8'h10 || e !== 3'b000 || l !== 1'b0) begin
      errors++;
      $display("FAIL t4_b0 ok=%0b data=%h err=%b last=%b required 10 000 0",
               ok, d, e, l);
    end
    recv(d, e, l, s, ok);
    checks++;
    if (!ok || d !== 8'h11 || e !== 3'b001 || l !== 1'b1 || s !== 1'b1) begin
      errors++;
      $display("FAIL t4_b1 ok=%0b data=%h err=%b last=%b sticky=%b required 11 001 1 1",
               ok, d, e, l, s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pop_cnt - base !== 2 || rf_count !== 5'd2 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL t4_stop pops=%0d count=%0d sticky=%b required 2 2 1",
               pop_cnt - base, rf_count, err_sticky);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL t4_clr sticky=%b required 0", err_sticky);
    end
    push(8'h14, 3'b010);
    err_clr = 1'b1;
    counter_t = 10'd0;
    for (int i = 0; i < 3; i++) begin
      recv(d, e, l, s, ok);
      checks++;
      if (!ok || d !== 8'(8'h12 + i) || l !== (i == 2) ||
          e !== ((i == 2) ? 3'b010 : 3'b000) || s !== (i == 2)) begin
        errors++;
        $display("FAIL t4_to%0d ok=%0b data=%h err=%b last=%b sticky=%b required %h %b %b %b",
                 i, ok, d, e, l, s, 8'(8'h12 + i),
                 ((i == 2) ? 3'b010 : 3'b000), (i == 2), (i == 2));
      end
    end
    err_clr = 1'b0;
    counter_t = 10'd100;
    drain_en = 1'b0;
  endtask

  task automatic test_stall_reset();
    int base;
    int bad;
    bit seen;
    do_reset();
    fcr_trig = 2'b01;
    for (int i = 0; i < 4; i++) push(8'(8'h71 + i), 3'b000);
    base = pop_cnt;
    sif.m_ready = 1'b0;
    drain_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sif.m_valid;
    end
    checks++;
    if (!seen || sif.m_data !== 8'h71) begin
      errors++;
      $display("FAIL t5_first seen=%0b data=%h required 1 71", seen, sif.m_data);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sif.m_valid !== 1'b1 || sif.m_data !== 8'h71) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL t5_hold unstable_cycles=%0d required 0", bad);
    end
    checks++;
    if (pop_cnt - base !== 1 || rf_count !== 5'd3) begin
      errors++;
      $display("FAIL t5_pops pops=%0d count=%0d required 1 3",
               pop_cnt - base, rf_count);
    end
    wb_rst_i = 1'b1;
    drain_en = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_rst valid=%b required 0", sif.m_valid);
    end
    wb_rst_i = 1'b0;
    sif.m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sif.m_valid !== 1'b0 || sif.m_data !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0 || pop_cnt - base !== 1) begin
      errors++;
      $display("FAIL t5_idle bad=%0d pops=%0d required 0 1", bad, pop_cnt - base);
    end
  endtask

  task automatic test_drain_off();
    logic [7:0] d; logic [2:0] e; logic l; logic s; bit ok;
    int base;
    int bad;
    bit seen;
    do_reset();
    fcr_trig = 2'b00;
    for (int i = 0; i < 6; i++) push(8'(8'h81 + i), 3'b000);
    base = pop_cnt;
    sif.m_ready = 1'b0;
    drain_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sif.m_valid;
    end
    checks++;
    if (!seen || sif.m_data !== 8'h81 || sif.m_last !== 1'b0) begin
      errors++;
      $display("FAIL t6_first seen=%0b data=%h last=%b required 1 81 0",
               seen, sif.m_data, sif.m_last);
    end
    drain_en = 1'b0;
    sif.m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.m_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || pop_cnt - base !== 1 || rf_count !== 5'd5) begin
      errors++;
      $display("FAIL t6_stop bad=%0d pops=%0d count=%0d required 0 1 5",
               bad, pop_cnt - base, rf_count);
    end
    drain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      recv(d, e, l, s, ok);
      checks++;
      if (!ok || d !== 8'(8'h82 + i) || l !== (i == 4)) begin
        errors++;
        $display("FAIL t6_byte%0d ok=%0b data=%h last=%b required data=%h last=%b",
                 i, ok, d, l, 8'(8'h82 + i), (i == 4));
      end
    end
    @(negedge clk);
    checks++;
    if (pop_cnt - base !== 6) begin
      errors++;
      $display("FAIL t6_pops got=%0d required 6", pop_cnt - base);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_pop_rules();
    checks++;
    if (pop_viol !== 0) begin
      errors++;
      $display("FAIL pop_rules violations=%0d required 0", pop_viol);
    end
  endtask

  initial begin
    sif.m_ready = 1'b0;
    test_reset();
    test_trig4();
    test_timeout();
    test_max_burst();
    test_stop_on_err();
    test_stall_reset();
    test_drain_off();
    test_pop_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
